// File: rtl/cim_mux_n_pkg.sv
// Shared constants, the tag-width helper and the readout state encoding for cim_mux_n.
package cim_mux_n_pkg;

  localparam int mix_shift = 16;

  // Channel-index width inside a tag: max(1, clog2(n)).
  function automatic int tag_cw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } rd_state_e;

endpackage

// File: rtl/cim_mux_n_chan.sv
// One channel: LO pair select, cos/sin mixers, product regs, double integrators, snapshot.
module cim_chan
  import cim_mux_n_pkg::*;
#(
  parameter int dwi   = 16,
  parameter int mw    = 18,
  parameter int dw    = 32,
  parameter bit use_b = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic signed [dwi-1:0] adc,
  input  logic signed [mw-1:0]  cosa,
  input  logic signed [mw-1:0]  sina,
  input  logic signed [mw-1:0]  cosb,
  input  logic signed [mw-1:0]  sinb,
  input  logic                  snap,
  output logic [dw-1:0]         live_cos,
  output logic [dw-1:0]         snap_cos,
  output logic [dw-1:0]         snap_sin
);

  logic signed [mw-1:0]     lo_cos, lo_sin;
  logic signed [dwi+mw-1:0] prod_cos, prod_sin;
  logic signed [dwi+1:0]    p_cos, p_sin;
  logic [dw-1:0]            i1_cos, i1_sin, i2_cos, i2_sin;

  assign lo_cos   = use_b ? cosb : cosa;
  assign lo_sin   = use_b ? sinb : sina;
  assign prod_cos = adc * lo_cos;
  assign prod_sin = adc * lo_sin;
  assign live_cos = i2_cos;

  // Taking bits above mix_shift is the floor arithmetic shift; integrators wrap freely.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_cos    <= '0;
      p_sin    <= '0;
      i1_cos   <= '0;
      i1_sin   <= '0;
      i2_cos   <= '0;
      i2_sin   <= '0;
      snap_cos <= '0;
      snap_sin <= '0;
    end else begin
      p_cos  <= prod_cos[mix_shift +: dwi+2];
      p_sin  <= prod_sin[mix_shift +: dwi+2];
      i1_cos <= i1_cos + {{(dw-dwi-2){p_cos[dwi+1]}}, p_cos};
      i1_sin <= i1_sin + {{(dw-dwi-2){p_sin[dwi+1]}}, p_sin};
      i2_cos <= i2_cos + i1_cos;
      i2_sin <= i2_sin + i1_sin;
      if (snap) begin
        snap_cos <= i2_cos;
        snap_sin <= i2_sin;
      end
    end
  end

endmodule

// File: rtl/cim_mux_n.sv
// N-channel cascaded-integrator mixer with snapshot and serial tagged readout.
module cim_mux_n
  import cim_mux_n_pkg::*;
#(
  parameter int               nchan  = 6,
  parameter int               dwi    = 16,
  parameter int               mw     = 18,
  parameter int               dw     = 32,
  parameter logic [nchan-1:0] lo_sel = 6'b100000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [nchan*dwi-1:0]    adc,
  input  logic signed [mw-1:0]    cosa,
  input  logic signed [mw-1:0]    sina,
  input  logic signed [mw-1:0]    cosb,
  input  logic signed [mw-1:0]    sinb,
  input  logic [nchan-1:0]        chan_en,
  input  logic                    sample,
  input  logic                    overrun_clr,
  output logic [dw-1:0]           sr_out,
  output logic                    sr_val,
  output logic [tag_cw(nchan):0]  sr_tag,
  output logic                    sr_last,
  output logic                    busy,
  output logic                    overrun
);

  localparam int cw = tag_cw(nchan);

  rd_state_e        state;
  logic [nchan-1:0] mask;
  logic [dw-1:0]    live_cos [nchan];
  logic [dw-1:0]    snap_cos [nchan];
  logic [dw-1:0]    snap_sin [nchan];
  logic             accept;
  logic [cw:0]      first_s, next_s;
  logic [cw-1:0]    cur_ch;

  // Lowest set bit of m at or above start; MSB of the result flags "found".
  function automatic logic [cw:0] find_from(input logic [nchan-1:0] m, input int start);
    logic [cw:0] r;
    r = '0;
    for (int k = nchan - 1; k >= 0; k--) begin
      if (k >= start && m[k]) r = {1'b1, k[cw-1:0]};
    end
    return r;
  endfunction

  for (genvar k = 0; k < nchan; k++) begin : g_chan
    cim_chan #(.dwi(dwi), .mw(mw), .dw(dw), .use_b(lo_sel[k])) u_chan (
      .clk      (clk),
      .rst      (rst),
      .adc      (adc[k*dwi +: dwi]),
      .cosa     (cosa),
      .sina     (sina),
      .cosb     (cosb),
      .sinb     (sinb),
      .snap     (accept),
      .live_cos (live_cos[k]),
      .snap_cos (snap_cos[k]),
      .snap_sin (snap_sin[k])
    );
  end

  assign accept = sample && (!busy || sr_last);
  assign cur_ch = sr_tag[cw:1];

  // The first word comes straight from the live integrator: the snapshot lands on the same edge.
  always_comb begin
    first_s = find_from(chan_en, 0);
    next_s  = find_from(mask, int'(cur_ch) + 1);
  end

  // Readout FSM, overrun flag and registered serial outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      mask    <= '0;
      sr_out  <= '0;
      sr_val  <= 1'b0;
      sr_tag  <= '0;
      sr_last <= 1'b0;
      busy    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (sample && !accept) overrun <= 1'b1;
      else if (overrun_clr)  overrun <= 1'b0;

      if (accept && first_s[cw]) begin
        mask    <= chan_en;
        state   <= ST_SHIFT;
        busy    <= 1'b1;
        sr_val  <= 1'b1;
        sr_last <= 1'b0;
        sr_tag  <= {first_s[cw-1:0], 1'b0};
        sr_out  <= live_cos[first_s[cw-1:0]];
      end else if (!accept && state == ST_SHIFT && !sr_last) begin
        busy   <= 1'b1;
        sr_val <= 1'b1;
        if (!sr_tag[0]) begin
          sr_out  <= snap_sin[cur_ch];
          sr_tag  <= {cur_ch, 1'b1};
          sr_last <= !next_s[cw];
        end else begin
          sr_out  <= snap_cos[next_s[cw-1:0]];
          sr_tag  <= {next_s[cw-1:0], 1'b0};
          sr_last <= 1'b0;
        end
      end else begin
        if (accept) mask <= chan_en;
        state   <= ST_IDLE;
        busy    <= 1'b0;
        sr_val  <= 1'b0;
        sr_last <= 1'b0;
        sr_tag  <= '0;
        sr_out  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_cim_mux_n.sv
// Directed self-checking bench for cim_mux_n with hand-derived expected words.
module tb_cim_mux_n;

  localparam int nchan = 6;
  localparam int dwi   = 16;
  localparam int mw    = 18;
  localparam int dw    = 32;
  localparam int cw    = 3;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [nchan*dwi-1:0]   adc;
  logic signed [mw-1:0]   cosa, sina, cosb, sinb;
  logic [nchan-1:0]       chan_en;
  logic                   sample, overrun_clr;
  logic [dw-1:0]          sr_out;
  logic                   sr_val;
  logic [cw:0]            sr_tag;
  logic                   sr_last, busy, overrun;

  int nchk = 0;
  int nfail = 0;
  int cyc = 0;

  logic          ev, el, eb;
  logic [cw:0]   et;
  logic [dw-1:0] eo;

  cim_mux_n dut (
    .clk(clk), .rst(rst), .adc(adc), .cosa(cosa), .sina(sina), .cosb(cosb), .sinb(sinb),
    .chan_en(chan_en), .sample(sample), .overrun_clr(overrun_clr),
    .sr_out(sr_out), .sr_val(sr_val), .sr_tag(sr_tag), .sr_last(sr_last),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Leaves the bench in cycle 0 (first cycle with rst low).
  task automatic do_reset;
    rst = 1'b1; sample = 1'b0; overrun_clr = 1'b0;
    tick; tick;
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick;
  endtask

  task automatic set_adc(input int k, input int v);
    adc[k*dwi +: dwi] = 16'(v);
  endtask

  // i2 at cycle k for constant product p starting in cycle 1: p*(k-1)*(k-2)/2 mod 2^32.
  function automatic logic [31:0] i2_model(input longint p, input int k);
    longint n;
    n = longint'(k - 1);
    return 32'(p * n * (n - 1) / 2);
  endfunction

  task automatic test_reset;
    adc = '0; cosa = 18'sd65536; sina = 18'sd0; cosb = 18'sd0; sinb = 18'sd0;
    chan_en = '0;
    do_reset;
    nchk++;
    if ({sr_val, sr_last, busy, overrun, sr_tag, sr_out} !== 40'd0) begin
      nfail++;
      $display("FAIL reset_state: got val=%b last=%b busy=%b ovr=%b tag=%h out=%0d, want all zero",
               sr_val, sr_last, busy, overrun, sr_tag, sr_out);
    end
  endtask

  task automatic test_single;
    adc = '0; set_adc(0, 1000);
    cosa = 18'sd65536; sina = 18'sd0; cosb = 18'sd0; sinb = 18'sd0;
    do_reset;
    run_to(10);
    nchk++;
    if (busy !== 1'b0) begin nfail++; $display("FAIL single_busy10: got %b want 0", busy); end
    chan_en = 6'b000001; sample = 1'b1;
    tick; sample = 1'b0;
    for (int w = 0; w < 3; w++) begin
      ev = (w < 2); el = (w == 1); eb = (w < 2);
      et = (w == 1) ? 4'h1 : 4'h0;
      eo = (w == 0) ? 32'd36000 : 32'd0;
      nchk++;
      if ({sr_val, sr_last, busy, sr_tag, sr_out} !== {ev, el, eb, et, eo}) begin
        nfail++;
        $display("FAIL single_w%0d: got val=%b last=%b busy=%b tag=%h out=%0d, want val=%b last=%b busy=%b tag=%h out=%0d",
                 w, sr_val, sr_last, busy, sr_tag, $signed(sr_out), ev, el, eb, et, $signed(eo));
      end
      tick;
    end
  endtask

  task automatic test_mask;
    logic [dw-1:0] exp_o [6];
    logic [cw:0]   exp_t [6];
    exp_o[0] = 32'd36000;  exp_o[1] = 32'd18000;  exp_o[2] = -32'sd72000;
    exp_o[3] = -32'sd36000; exp_o[4] = -32'sd10836; exp_o[5] = 32'd2700;
    exp_t[0] = 4'h0; exp_t[1] = 4'h1; exp_t[2] = 4'h4;
    exp_t[3] = 4'h5; exp_t[4] = 4'hA; exp_t[5] = 4'hB;
    for (int k = 0; k < nchan; k++) set_adc(k, 5000);
    set_adc(0, 1000); set_adc(2, -2000); set_adc(5, 301);
    cosa = 18'sd65536; sina = 18'sd32768; cosb = -18'sd65536; sinb = 18'sd16384;
    do_reset;
    run_to(10);
    chan_en = 6'b100101; sample = 1'b1;
    tick; sample = 1'b0;
    for (int w = 0; w < 7; w++) begin
      ev = (w < 6); el = (w == 5); eb = (w < 6);
      et = (w < 6) ? exp_t[w] : 4'h0;
      eo = (w < 6) ? exp_o[w] : 32'd0;
      nchk++;
      if ({sr_val, sr_last, busy, sr_tag, sr_out} !== {ev, el, eb, et, eo}) begin
        nfail++;
        $display("FAIL mask_w%0d: got val=%b last=%b busy=%b tag=%h out=%0d, want val=%b last=%b busy=%b tag=%h out=%0d",
                 w, sr_val, sr_last, busy, sr_tag, $signed(sr_out), ev, el, eb, et, $signed(eo));
      end
      tick;
    end
  endtask

  task automatic test_overrun;
    int a;
    for (int k = 0; k < nchan; k++) set_adc(k, 100 * (k + 1));
    cosa = 18'sd65536; sina = 18'sd32768; cosb = -18'sd65536; sinb = 18'sd16384;
    do_reset;
    run_to(10);
    chan_en = 6'b111111; sample = 1'b1;
    tick; sample = 1'b0;
    for (int w = 0; w < 12; w++) begin
      a = 100 * (w / 2 + 1);
      if (w / 2 == 5) eo = (w % 2 == 0) ? 32'(-a * 36) : 32'((a / 4) * 36);
      else            eo = (w % 2 == 0) ? 32'(a * 36)  : 32'((a / 2) * 36);
      ev = 1'b1; el = (w == 11); eb = 1'b1;
      et = {3'(w / 2), 1'(w % 2)};
      nchk++;
      if ({sr_val, sr_last, busy, sr_tag, sr_out, overrun} !== {ev, el, eb, et, eo, 1'(w >= 3)}) begin
        nfail++;
        $display("FAIL overrun_frame_w%0d: got val=%b last=%b busy=%b tag=%h out=%0d ovr=%b, want val=%b last=%b busy=%b tag=%h out=%0d ovr=%b",
                 w, sr_val, sr_last, busy, sr_tag, $signed(sr_out), overrun, ev, el, eb, et, $signed(eo), (w >= 3));
      end
      sample = (w == 2);
      tick;
    end
    sample = 1'b0;
    nchk++;
    if ({sr_val, busy, overrun} !== 3'b001) begin
      nfail++; $display("FAIL overrun_after_frame: got val=%b busy=%b ovr=%b want 0 0 1", sr_val, busy, overrun);
    end
    overrun_clr = 1'b1; tick; overrun_clr = 1'b0;
    nchk++;
    if (overrun !== 1'b0) begin nfail++; $display("FAIL overrun_clr: got %b want 0", overrun); end
    chan_en = 6'b000001; sample = 1'b1; tick;
    overrun_clr = 1'b1; tick;
    sample = 1'b0; overrun_clr = 1'b0;
    nchk++;
    if ({overrun, sr_last, busy} !== 3'b111) begin
      nfail++; $display("FAIL overrun_clr_vs_reject: got ovr=%b last=%b busy=%b want 1 1 1", overrun, sr_last, busy);
    end
    tick;
    overrun_clr = 1'b1; tick; overrun_clr = 1'b0;
  endtask

  task automatic test_back_to_back;
    chan_en = 6'b000100; sample = 1'b1; tick; sample = 1'b0;
    tick;
    nchk++;
    if ({sr_val, sr_last, busy, sr_tag} !== {3'b111, 4'h5}) begin
      nfail++; $display("FAIL b2b_first_last: got val=%b last=%b busy=%b tag=%h want 1 1 1 5", sr_val, sr_last, busy, sr_tag);
    end
    chan_en = 6'b100000; sample = 1'b1; tick; sample = 1'b0;
    nchk++;
    if ({sr_val, sr_last, busy, sr_tag, overrun} !== {3'b101, 4'hA, 1'b0}) begin
      nfail++; $display("FAIL b2b_second_start: got val=%b last=%b busy=%b tag=%h ovr=%b want 1 0 1 a 0", sr_val, sr_last, busy, sr_tag, overrun);
    end
    tick;
    nchk++;
    if ({sr_val, sr_last, busy, sr_tag} !== {3'b111, 4'hB}) begin
      nfail++; $display("FAIL b2b_second_last: got val=%b last=%b busy=%b tag=%h want 1 1 1 b", sr_val, sr_last, busy, sr_tag);
    end
    tick;
    chan_en = 6'b000000; sample = 1'b1; tick; sample = 1'b0;
    for (int w = 0; w < 2; w++) begin
      nchk++;
      if ({sr_val, busy, overrun, sr_out} !== 35'd0) begin
        nfail++; $display("FAIL zero_mask_c%0d: got val=%b busy=%b ovr=%b out=%0d want 0 0 0 0", w, sr_val, busy, overrun, sr_out);
      end
      tick;
    end
  endtask

  task automatic test_wrap;
    int ks [2];
    ks[0] = 1000; ks[1] = 1500;
    adc = '0; set_adc(0, 32767);
    cosa = 18'sd131071; sina = -18'sd1; cosb = 18'sd0; sinb = 18'sd0;
    do_reset;
    for (int s = 0; s < 2; s++) begin
      run_to(ks[s]);
      chan_en = 6'b000001; sample = 1'b1; tick; sample = 1'b0;
      nchk++;
      if (sr_out !== i2_model(64'sd65533, ks[s])) begin
        nfail++; $display("FAIL wrap_cos_k%0d: got %h want %h", ks[s], sr_out, i2_model(64'sd65533, ks[s]));
      end
      tick;
      nchk++;
      if (sr_out !== i2_model(-64'sd1, ks[s])) begin
        nfail++; $display("FAIL wrap_sin_k%0d: got %h want %h", ks[s], sr_out, i2_model(-64'sd1, ks[s]));
      end
      tick;
    end
  endtask

  task automatic test_reset_mid;
    adc = '0; set_adc(0, 1000);
    cosa = 18'sd65536; sina = 18'sd0; cosb = 18'sd0; sinb = 18'sd0;
    do_reset;
    run_to(10);
    chan_en = 6'b000001; sample = 1'b1; tick;
    rst = 1'b1; tick;
    rst = 1'b0; sample = 1'b0; cyc = 0;
    for (int w = 0; w < 2; w++) begin
      nchk++;
      if ({sr_val, busy, overrun, sr_last, sr_out} !== 36'd0) begin
        nfail++; $display("FAIL rst_mid_c%0d: got val=%b busy=%b ovr=%b last=%b out=%0d want all 0", w, sr_val, busy, overrun, sr_last, sr_out);
      end
      tick;
    end
    run_to(10);
    sample = 1'b1; tick; sample = 1'b0;
    nchk++;
    if ({sr_val, sr_tag, sr_out} !== {1'b1, 4'h0, 32'd36000}) begin
      nfail++; $display("FAIL rst_restart_w0: got val=%b tag=%h out=%0d want 1 0 36000", sr_val, sr_tag, sr_out);
    end
    tick;
    nchk++;
    if ({sr_val, sr_last, sr_tag, sr_out} !== {2'b11, 4'h1, 32'd0}) begin
      nfail++; $display("FAIL rst_restart_w1: got val=%b last=%b tag=%h out=%0d want 1 1 1 0", sr_val, sr_last, sr_tag, sr_out);
    end
    tick;
  endtask

  initial begin
    rst = 1'b1; sample = 1'b0; overrun_clr = 1'b0; adc = '0; chan_en = '0;
    cosa = '0; sina = '0; cosb = '0; sinb = '0;
    test_reset;
    test_single;
    test_mask;
    test_overrun;
    test_back_to_back;
    test_wrap;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
